debug_slave_sysclk_cmdq: RTL and testbench
==========================================

Name: debug_slave_sysclk_cmdq

Overview:
- System-clock half of the CPU JTAG debug slave, parametrised successor to the fixed 38-bit/2-bit-IR sysclk stage.
- Synchronises the virtual-JTAG update strobes (vs_udr, vs_uir) coming from the TCK domain.
- Captures the scanned shift register together with its IR into a command FIFO, and presents each command to the OCI logic with a valid/ready handshake, instead of firing single-cycle take_action pulses.
- Adds queue depth, an overflow flag and IR-update notification.

Parameters:
- SR_WIDTH, 38, width of the scanned shift register and of cmd_data.
- IR_WIDTH, 2, width of the virtual IR.
- SYNC_STAGES, 2, synchroniser flops per strobe; legal values 2..4.
- QDEPTH, 4, FIFO entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- vs_udr  in  1  update-DR level strobe, TCK domain, asynchronous to clk.
- vs_uir  in  1  update-IR level strobe, TCK domain, asynchronous to clk.
- ir_in  in  IR_WIDTH  current virtual IR; quasi-static.
- sr  in  SR_WIDTH  scanned data; quasi-static around UDR.
- cmd_valid  out  1  FIFO head is valid.
- cmd_ready  in  1  consumer accepts the head.
- cmd_data  out  SR_WIDTH  head data (jdo equivalent).
- cmd_ir  out  IR_WIDTH  IR captured with the head entry.
- cmd_act  out  1  head action bit, equal to cmd_data[SR_WIDTH-1].
- cur_ir  out  IR_WIDTH  IR latched at the last UIR.
- ir_update  out  1  one-cycle pulse on each new IR.
- q_count  out  $clog2(QDEPTH+1)  occupancy.
- overflow  out  1  sticky: a command was dropped.

Behaviour:
- Reset (async assert, sync release):
  - All synchroniser and edge flops = 0.
  - FIFO pointers = 0, q_count = 0, cmd_valid = 0.
  - cmd_data, cmd_ir, cmd_act, cur_ir = 0.
  - ir_update = 0, overflow = 0.
  - Reset mid-operation discards all queued entries; no partial handshake survives.
- Synchronisers:
  - Each strobe passes through SYNC_STAGES flops, then a one-flop delayed copy.
  - rise = sync_out & ~delayed. Only rising edges act; a level held high never retriggers.
- Producer contract: sr and ir_in are stable from the vs_udr rise until SYNC_STAGES+2 clk cycles after it. The TCK side guarantees this because it does not shift until the next SDR.
- Enqueue:
  - On the clk edge where udr rise = 1, {ir_in, sr} is written at the write pointer if the FIFO is not full.
  - Latency: the first clk edge that samples vs_udr high is edge 0. The write happens at edge SYNC_STAGES. cmd_valid is visible after that edge (SYNC_STAGES+1 cycles from the strobe).
  - No fall-through bypass.
- Dequeue:
  - Entry is popped at a clk edge with cmd_valid & cmd_ready; the next entry appears after that edge.
  - cmd_data, cmd_ir and cmd_act are stable while cmd_valid & ~cmd_ready.
  - cmd_data, cmd_ir and cmd_act read as 0 when empty.
- Full/empty:
  - Simultaneous push and pop when full: both happen; count unchanged; no overflow.
  - Push when full without pop: entry dropped and overflow set at that edge.
  - Pop when empty: ignored.
  - Simultaneous push and pop when empty: push only (cmd_valid was 0).
  - Pointers are log2(QDEPTH) bits and wrap naturally; q_count tracks occupancy 0..QDEPTH.
- IR update:
  - On uir rise: cur_ir <= ir_in, ir_update = 1 for exactly that cycle (registered), overflow cleared.
  - If an overflowing drop and a uir rise occur at the same edge, the set wins and overflow = 1.
  - udr and uir rising at the same edge are both processed. The enqueued entry carries the ir_in sampled at that edge.
- Back-to-back: consecutive udr rises separated by at least SYNC_STAGES+2 clk cycles are each captured exactly once.

Test Plan:
- Reset, QDEPTH=4, SYNC_STAGES=2 -> cmd_valid=0, q_count=0, overflow=0, cur_ir=0, all outputs 0 before and immediately after reset_n rises.
- ir_in=2'b01, pulse vs_uir high for 6 clk -> exactly one ir_update pulse; cur_ir=2'b01; no enqueue.
- sr=38'h20_0000_1234, ir_in=2'b10, vs_udr high for 6 clk, cmd_ready=0 -> cmd_valid rises 3 cycles after the strobe is first sampled; cmd_data=38'h20_0000_1234, cmd_ir=2'b10, cmd_act=1, q_count=1; held stable for 10 cycles; cmd_ready=1 for one cycle -> cmd_valid=0, q_count=0.
- Five UDR strobes with sr=1..5, cmd_ready=0 -> q_count=4, overflow=1; drain with cmd_ready=1 -> cmd_data yields 1,2,3,4 on consecutive cycles; then a vs_uir pulse -> overflow=0.
- FIFO full with cmd_ready=1 continuously while a 5th UDR arrives -> the pop and push occur on the same edge; overflow stays 0; 5 entries delivered in order; pointer wrap is exercised.
- reset_n asserted asynchronously mid-clock with q_count=3 -> cmd_valid and q_count drop to 0 without waiting for a clk edge; after release, one UDR yields exactly one entry.

Source files
------------

// File: rtl/debug_slave_sysclk_cmdq.sv
// System-clock side of the CPU JTAG debug slave: synchronises the TCK-domain update
// strobes and queues each scanned {IR, SR} command for the OCI logic.
module debug_slave_sysclk_cmdq #(
  parameter int SR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int SYNC_STAGES = 2,   // 2..4
  parameter int QDEPTH      = 4    // power of 2, >= 2
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             vs_udr,
  input  logic                             vs_uir,
  input  logic [IR_WIDTH-1:0]              ir_in,
  input  logic [SR_WIDTH-1:0]              sr,
  output logic                             cmd_valid,
  input  logic                             cmd_ready,
  output logic [SR_WIDTH-1:0]              cmd_data,
  output logic [IR_WIDTH-1:0]              cmd_ir,
  output logic                             cmd_act,
  output logic [IR_WIDTH-1:0]              cur_ir,
  output logic                             ir_update,
  output logic [$clog2(QDEPTH+1)-1:0]      q_count,
  output logic                             overflow
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int ENT_W = IR_WIDTH + SR_WIDTH;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

  logic [SYNC_STAGES-1:0] udr_sync;
  logic [SYNC_STAGES-1:0] uir_sync;
  logic                   udr_dly;
  logic                   uir_dly;
  logic                   udr_rise;
  logic                   uir_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync <= '0;
      uir_sync <= '0;
      udr_dly  <= 1'b0;
      uir_dly  <= 1'b0;
    end else begin
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_dly  <= udr_sync[SYNC_STAGES-1];
      uir_dly  <= uir_sync[SYNC_STAGES-1];
    end
  end

  // Only rising edges act; a strobe held high for many clocks fires once.
  assign udr_rise = udr_sync[SYNC_STAGES-1] & ~udr_dly;
  assign uir_rise = uir_sync[SYNC_STAGES-1] & ~uir_dly;

  logic [ENT_W-1:0] mem [QDEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             push;
  logic             pop;
  logic             drop;
  logic [ENT_W-1:0] head;

  // Handshake: the head transfers on any clk edge where cmd_valid & cmd_ready; while
  // cmd_valid is high and cmd_ready low, cmd_data/cmd_ir/cmd_act hold their value.
  assign full      = (count == FULL_CNT);
  assign cmd_valid = (count != '0);
  assign pop       = cmd_valid & cmd_ready;
  assign push      = udr_rise & (~full | pop);
  assign drop      = udr_rise & full & ~pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {ir_in, sr};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset, so the head is masked to zero whenever the queue is empty.
  assign head     = mem[rd_ptr];
  assign cmd_data = cmd_valid ? head[SR_WIDTH-1:0] : '0;
  assign cmd_ir   = cmd_valid ? head[ENT_W-1:SR_WIDTH] : '0;
  assign cmd_act  = cmd_data[SR_WIDTH-1];
  assign q_count  = count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_ir    <= '0;
      ir_update <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      ir_update <= uir_rise;
      if (uir_rise) cur_ir <= ir_in;
      // A drop on the same edge as an IR update must stay visible.
      if (drop)          overflow <= 1'b1;
      else if (uir_rise) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_debug_slave_sysclk_cmdq.sv
// Bench for debug_slave_sysclk_cmdq: directed vector table, randomized strobes against
// a queue-based reference model, and an asynchronous mid-operation reset sequence.
module tb_debug_slave_sysclk_cmdq;

  localparam int SR_W  = 38;
  localparam int IR_W  = 2;
  localparam int SYNC  = 2;
  localparam int QD    = 4;
  localparam int CNT_W = 3;
  localparam int ENT_W = IR_W + SR_W;

  logic              clk;
  logic              reset_n;
  logic              vs_udr;
  logic              vs_uir;
  logic [IR_W-1:0]   ir_in;
  logic [SR_W-1:0]   sr;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [SR_W-1:0]   cmd_data;
  logic [IR_W-1:0]   cmd_ir;
  logic              cmd_act;
  logic [IR_W-1:0]   cur_ir;
  logic              ir_update;
  logic [CNT_W-1:0]  q_count;
  logic              overflow;

  debug_slave_sysclk_cmdq #(
    .SR_WIDTH(SR_W), .IR_WIDTH(IR_W), .SYNC_STAGES(SYNC), .QDEPTH(QD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .ir_in(ir_in), .sr(sr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_ir(cmd_ir), .cmd_act(cmd_act), .cur_ir(cur_ir),
    .ir_update(ir_update), .q_count(q_count), .overflow(overflow)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ---------------- scoreboard bookkeeping ----------------
  int total  = 0;
  int passed = 0;
  int upd_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // A strobe first sampled high at edge k acts at edge k+SYNC; entries live in exp_q.
  logic [ENT_W-1:0] exp_q[$];
  logic             udr_h[$];
  logic             uir_h[$];
  logic             m_ovf;
  logic             m_upd;
  logic [IR_W-1:0]  m_cur;

  task automatic model_reset();
    exp_q.delete();
    udr_h.delete();
    uir_h.delete();
    repeat (SYNC + 2) begin
      udr_h.push_back(1'b0);
      uir_h.push_back(1'b0);
    end
    m_ovf = 1'b0;
    m_upd = 1'b0;
    m_cur = '0;
  endtask

  task automatic model_edge();
    logic udr_go, uir_go, do_pop, was_full, dropped;
    udr_h.push_back(vs_udr);
    void'(udr_h.pop_front());
    uir_h.push_back(vs_uir);
    void'(uir_h.pop_front());
    udr_go   = udr_h[1] & ~udr_h[0];
    uir_go   = uir_h[1] & ~uir_h[0];
    do_pop   = (exp_q.size() > 0) && cmd_ready;
    was_full = (exp_q.size() == QD);
    dropped  = 1'b0;
    if (do_pop) void'(exp_q.pop_front());
    if (udr_go) begin
      if (!was_full || do_pop) exp_q.push_back({ir_in, sr});
      else dropped = 1'b1;
    end
    m_upd = uir_go;
    if (uir_go) m_cur = ir_in;
    if (dropped)     m_ovf = 1'b1;
    else if (uir_go) m_ovf = 1'b0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_edge();
    end
  end

  // Every cycle the DUT outputs are compared against the model on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (ir_update === 1'b1) upd_cnt++;
      chk("m_valid", cmd_valid, exp_q.size() > 0);
      chk("m_data",  cmd_data,  exp_q.size() > 0 ? exp_q[0][SR_W-1:0] : '0);
      chk("m_ir",    cmd_ir,    exp_q.size() > 0 ? exp_q[0][ENT_W-1:SR_W] : '0);
      chk("m_act",   cmd_act,   exp_q.size() > 0 ? exp_q[0][SR_W-1] : 1'b0);
      chk("m_count", q_count,   exp_q.size());
      chk("m_cur_ir", cur_ir,   m_cur);
      chk("m_ir_update", ir_update, m_upd);
      chk("m_overflow", overflow, m_ovf);
    end
  end

  // ---------------- driver ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe_udr(input logic [IR_W-1:0] ir, input logic [SR_W-1:0] d);
    ir_in  = ir;
    sr     = d;
    vs_udr = 1'b1;
    step(2);
    vs_udr = 1'b0;
    step(4);
  endtask

  typedef struct {
    logic             udr;
    logic             uir;
    logic             rdy;
    logic [IR_W-1:0]  ir;
    logic [SR_W-1:0]  sr;
    int               cyc;
    logic             chk;
    logic             e_valid;
    logic [SR_W-1:0]  e_data;
    logic [IR_W-1:0]  e_ir;
    logic             e_act;
    logic [CNT_W-1:0] e_cnt;
    logic             e_ovf;
    logic [IR_W-1:0]  e_cur;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic udr, uir, rdy, input logic [IR_W-1:0] ir,
                              input logic [SR_W-1:0] d, input int cyc, input logic c,
                              input logic ev, input logic [SR_W-1:0] ed,
                              input logic [IR_W-1:0] ei, input logic ea,
                              input logic [CNT_W-1:0] ec, input logic eo,
                              input logic [IR_W-1:0] ecur);
    vec_t v;
    v.udr = udr; v.uir = uir; v.rdy = rdy; v.ir = ir; v.sr = d; v.cyc = cyc; v.chk = c;
    v.e_valid = ev; v.e_data = ed; v.e_ir = ei; v.e_act = ea; v.e_cnt = ec;
    v.e_ovf = eo; v.e_cur = ecur;
    return v;
  endfunction

  // ---------------- test ----------------
  initial begin
    logic [63:0] r64;
    int hi;
    int lo;
    reset_n   = 1'b0;
    vs_udr    = 1'b0;
    vs_uir    = 1'b0;
    cmd_ready = 1'b0;
    ir_in     = '0;
    sr        = '0;

    // IR update: one pulse, no enqueue
    tbl.push_back(mk(0,1,0,2'b01,'0,6,1, 0,'0,0,0,0,0,2'b01));
    tbl.push_back(mk(0,0,0,2'b01,'0,4,1, 0,'0,0,0,0,0,2'b01));
    // single command: visible SYNC+1 cycles after first sample, held, then popped
    tbl.push_back(mk(1,0,0,2'b10,38'h20_0000_1234,2,1, 0,'0,0,0,0,0,2'b01));
    tbl.push_back(mk(1,0,0,2'b10,38'h20_0000_1234,1,1, 1,38'h20_0000_1234,2'b10,1,1,0,2'b01));
    tbl.push_back(mk(1,0,0,2'b10,38'h20_0000_1234,3,1, 1,38'h20_0000_1234,2'b10,1,1,0,2'b01));
    tbl.push_back(mk(0,0,0,2'b10,38'h20_0000_1234,10,1, 1,38'h20_0000_1234,2'b10,1,1,0,2'b01));
    tbl.push_back(mk(0,0,1,2'b10,38'h20_0000_1234,1,1, 0,'0,0,0,0,0,2'b01));
    // five strobes into a 4-deep queue: last one dropped
    for (int k = 1; k <= 5; k++) begin
      tbl.push_back(mk(1,0,0,2'b11,SR_W'(k),2,0, 0,'0,0,0,0,0,0));
      tbl.push_back(mk(0,0,0,2'b11,SR_W'(k),4,(k == 5), 1,38'd1,2'b11,0,4,1,2'b01));
    end
    tbl.push_back(mk(0,0,1,2'b11,38'd5,1,1, 1,38'd2,2'b11,0,3,1,2'b01));
    tbl.push_back(mk(0,0,1,2'b11,38'd5,1,1, 1,38'd3,2'b11,0,2,1,2'b01));
    tbl.push_back(mk(0,0,1,2'b11,38'd5,1,1, 1,38'd4,2'b11,0,1,1,2'b01));
    tbl.push_back(mk(0,0,1,2'b11,38'd5,1,1, 0,'0,0,0,0,1,2'b01));
    tbl.push_back(mk(0,1,0,2'b11,38'd5,3,1, 0,'0,0,0,0,0,2'b11));
    tbl.push_back(mk(0,0,0,2'b11,38'd5,3,1, 0,'0,0,0,0,0,2'b11));
    // fill, then push and pop on the same edge while full
    for (int k = 0; k < 4; k++) begin
      tbl.push_back(mk(1,0,0,2'b10,SR_W'(8'h11 + k),2,0, 0,'0,0,0,0,0,0));
      tbl.push_back(mk(0,0,0,2'b10,SR_W'(8'h11 + k),4,(k == 3), 1,38'h11,2'b10,0,4,0,2'b11));
    end
    tbl.push_back(mk(1,0,0,2'b10,38'h15,2,1, 1,38'h11,2'b10,0,4,0,2'b11));
    tbl.push_back(mk(0,0,1,2'b10,38'h15,1,1, 1,38'h12,2'b10,0,4,0,2'b11));
    tbl.push_back(mk(0,0,1,2'b10,38'h15,1,1, 1,38'h13,2'b10,0,3,0,2'b11));
    tbl.push_back(mk(0,0,1,2'b10,38'h15,1,1, 1,38'h14,2'b10,0,2,0,2'b11));
    tbl.push_back(mk(0,0,1,2'b10,38'h15,1,1, 1,38'h15,2'b10,0,1,0,2'b11));
    tbl.push_back(mk(0,0,1,2'b10,38'h15,1,1, 0,'0,0,0,0,0,2'b11));

    // reset values before and just after release
    #5;
    chk("rst_valid", cmd_valid, 0);
    chk("rst_count", q_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_cur_ir", cur_ir, 0);
    chk("rst_data", cmd_data, 0);
    step(2);
    reset_n = 1'b1;
    #1;
    chk("rel_valid", cmd_valid, 0);
    chk("rel_count", q_count, 0);
    chk("rel_upd", ir_update, 0);
    step(1);

    for (int i = 0; i < tbl.size(); i++) begin
      vs_udr    = tbl[i].udr;
      vs_uir    = tbl[i].uir;
      cmd_ready = tbl[i].rdy;
      ir_in     = tbl[i].ir;
      sr        = tbl[i].sr;
      step(tbl[i].cyc);
      if (tbl[i].chk) begin
        chk($sformatf("v%0d_valid", i), cmd_valid, tbl[i].e_valid);
        chk($sformatf("v%0d_data", i),  cmd_data,  tbl[i].e_data);
        chk($sformatf("v%0d_ir", i),    cmd_ir,    tbl[i].e_ir);
        chk($sformatf("v%0d_act", i),   cmd_act,   tbl[i].e_act);
        chk($sformatf("v%0d_count", i), q_count,   tbl[i].e_cnt);
        chk($sformatf("v%0d_ovf", i),   overflow,  tbl[i].e_ovf);
        chk($sformatf("v%0d_cur_ir", i), cur_ir,   tbl[i].e_cur);
      end
    end
    chk("ir_update_pulses", upd_cnt, 2);

    // randomized strobes; rises are always at least SYNC+2 cycles apart
    for (int it = 0; it < 250; it++) begin
      r64    = {$urandom(), $urandom()};
      sr     = r64[SR_W-1:0];
      ir_in  = IR_W'($urandom_range(0, 3));
      vs_udr = 1'($urandom_range(0, 1));
      vs_uir = ($urandom_range(0, 3) == 0);
      hi = $urandom_range(1, 3);
      lo = $urandom_range(3, 5);
      repeat (hi) begin
        cmd_ready = ($urandom_range(0, 3) == 0);
        step(1);
      end
      vs_udr = 1'b0;
      vs_uir = 1'b0;
      repeat (lo) begin
        cmd_ready = ($urandom_range(0, 3) == 0);
        step(1);
      end
    end

    cmd_ready = 1'b1;
    step(8);
    chk("drain_count", q_count, 0);

    // asynchronous reset with three entries queued
    cmd_ready = 1'b0;
    for (int k = 0; k < 3; k++) strobe_udr(2'b01, SR_W'(12'h100 + k));
    chk("pre_rst_count", q_count, 3);
    @(posedge clk);
    #4;
    reset_n = 1'b0;
    #1;
    chk("async_valid", cmd_valid, 0);
    chk("async_count", q_count, 0);
    chk("async_data", cmd_data, 0);
    step(2);
    reset_n = 1'b1;
    step(1);
    strobe_udr(2'b01, 38'h3f);
    chk("post_rst_count", q_count, 1);
    chk("post_rst_data", cmd_data, 38'h3f);
    chk("post_rst_ir", cmd_ir, 2'b01);
    cmd_ready = 1'b1;
    step(1);
    chk("post_rst_pop", q_count, 0);
    cmd_ready = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
